hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised hazard-interlock unit that generalises the fixed load-use bubble check into a per-register pending-write scoreboard. It sits beside the decode stage, tracks every in-flight destination register with a latency countdown, and stalls issue while a source operand is not yet forwardable. It also supports pipeline flush on taken branches and a halt-drain sequence that waits for all in-flight writes to retire.

Parameters:
NUM_REGS, 16, architectural register count (power of 2)
REG_W, 4, register index width, log2(NUM_REGS)
NUM_SRC, 2, source operands checked per issued instruction
MAX_LAT, 3, largest producer latency in cycles before the result is forwardable
LAT_W, 2, counter width, ceil(log2(MAX_LAT+1))
ZERO_REG, 1, when 1 register 0 is hardwired zero: never tracked, never causes a stall

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  asynchronous active-high reset
issue_valid  in  1  decode presents an instruction
issue_src  in  NUM_SRC*REG_W  source register indices; slot j at [j*REG_W +: REG_W]
issue_src_vld  in  NUM_SRC  per-slot source-used flag
issue_wr  in  1  instruction writes a register
issue_dst  in  REG_W  destination index
issue_lat  in  LAT_W  producer latency in cycles; 0 means forwardable next cycle
flush  in  1  squash all in-flight tracked writes (taken branch)
hlt_req  in  1  level; request halt-drain
issue_ready  out  1  instruction is accepted this cycle
stall  out  1  issue blocked by an operand hazard
busy_mask  out  NUM_REGS  bit r set when counter[r] != 0
halted  out  1  drain complete
stall_count  out  16  saturating count of stall cycles

Behaviour:
- Reset, asynchronous: every counter is 0, FSM is RUN, stall_count is 0. All outputs read 0: issue_ready=0, stall=0, busy_mask=0, halted=0.
- Counters: one LAT_W counter per register. Every cycle each nonzero counter decrements by 1.
- hazard = issue_valid & OR over j of (issue_src_vld[j] & counter[issue_src[j]] != 0). When ZERO_REG=1, an index of 0 never hazards.
- stall = (state==RUN) & hazard & ~flush. This is combinational from the registered counters.
- issue_ready = (state==RUN) & issue_valid & ~hazard & ~flush & ~hlt_req.
- Accepted issue with issue_wr set and a trackable dst: counter[dst] <= issue_lat. This overrides the decrement, so the youngest writer wins.
- issue_lat values above MAX_LAT saturate to MAX_LAT.
- Same-cycle issue writing register R while another source reads R: the hazard check uses the pre-update counter, so no self-stall.
- flush: all counters are cleared to 0 next edge, and any issue in that cycle is dropped (issue_ready=0, stall=0). Flush has priority over issue and hlt_req effects on counters. The FSM is unaffected.
- FSM:
  - RUN -> DRAIN when hlt_req=1. No issue is accepted in that cycle.
  - DRAIN: issue_ready=0 and stall=0. Goes to HALTED on the first cycle in which all counters are 0, which can be the entry cycle.
  - HALTED: halted=1, sticky until rst. hlt_req deassertion is ignored after leaving RUN.
- stall_count: +1 on each cycle with stall=1. It holds at 16'hFFFF.
- Reset mid-drain or mid-stall: immediate return to the reset state. No partial counter survives.

Decomposition:
- Shared package (cpu_pkg): FSM state encoding ST_RUN, ST_DRAIN, ST_HALTED as 2-bit localparams, plus the latency class constants LAT_ALU=0 and LAT_LOAD=1 that decode uses to drive issue_lat.
- One natural sub-module: sb_entry, a single register's load/decrement/clear counter with a busy output, instantiated NUM_REGS times via generate. Hazard compare, FSM and statistics stay in the top.

Test Plan:
- Load-use: issue wr dst=3 lat=1, next cycle issue src0=3 -> stall=1 for 1 cycle, issue_ready=1 the following cycle, stall_count=1.
- ALU back-to-back: issue wr dst=5 lat=0, next issue src1=5 -> stall=0, issue_ready=1, busy_mask=0.
- Zero register: ZERO_REG=1, issue wr dst=0 lat=3, then src0=0 -> no stall, busy_mask[0]=0. Repeat with ZERO_REG=0 -> stall for 3 cycles.
- Flush priority: dst=7 lat=3 accepted, next cycle flush=1 with issue src0=7 -> issue_ready=0, stall=0. busy_mask=0 next cycle, and the following issue of src0=7 is accepted.
- Halt drain: dst=2 lat=3 accepted, then hlt_req=1 -> issue_ready=0 while busy_mask!=0, halted=1 exactly 3 cycles after the issue edge. Assert rst mid-drain -> halted=0 and state RUN.
- Saturation and overwrite: dst=4 lat=3 then dst=4 lat=1 -> counter[4] reloads to 1 and busy clears after 1 cycle. Force 70000 stall cycles -> stall_count=16'hFFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared FSM encodings and decode latency classes for the
//           hazard scoreboard.
// Rev     : 1.0
// ============================================================================
package cpu_pkg;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // Latency classes decode drives onto issue_lat
  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;

endpackage
`default_nettype wire

// File: rtl/sb_entry.sv
`default_nettype none
// ============================================================================
// Module  : sb_entry
// Brief   : One register's pending-write countdown with load/decrement/clear.
// Rev     : 1.0
// ============================================================================
module sb_entry #(
  parameter int LAT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [LAT_W-1:0] i_lat,
  input  logic             i_clear,
  output logic             o_busy,
  output logic             o_busy_next
);

  logic [LAT_W-1:0] r_cnt;
  logic [LAT_W-1:0] w_cnt_next;

  // Clear beats load, load beats decrement (youngest writer wins)
  always_comb begin
    w_cnt_next = r_cnt;
    if (i_clear) begin
      w_cnt_next = '0;
    end else if (i_load) begin
      w_cnt_next = i_lat;
    end else if (r_cnt != '0) begin
      w_cnt_next = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign o_busy      = (r_cnt != '0);
  assign o_busy_next = (w_cnt_next != '0);

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : hazard_scoreboard
// Brief   : Per-register pending-write scoreboard with issue stall, flush and
//           halt-drain control.
// Rev     : 1.0
// ============================================================================
module hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int REG_W    = 4,
  parameter int NUM_SRC  = 2,
  parameter int MAX_LAT  = 3,
  parameter int LAT_W    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [NUM_SRC*REG_W-1:0] issue_src,
  input  logic [NUM_SRC-1:0]       issue_src_vld,
  input  logic                     issue_wr,
  input  logic [REG_W-1:0]         issue_dst,
  input  logic [LAT_W-1:0]         issue_lat,
  input  logic                     flush,
  input  logic                     hlt_req,
  output logic                     issue_ready,
  output logic                     stall,
  output logic [NUM_REGS-1:0]      busy_mask,
  output logic                     halted,
  output logic [15:0]              stall_count
);

  logic [NUM_REGS-1:0] w_busy;
  logic [NUM_REGS-1:0] w_busy_next;
  logic [NUM_REGS-1:0] w_load;
  logic [LAT_W-1:0]    w_lat_sat;
  logic                w_hazard;
  logic                w_run;
  logic [1:0]          r_state;
  logic [1:0]          w_state_next;
  logic [15:0]         r_stall_cnt;

  // Hazard uses the pre-update counters, so a same-cycle writer never self-stalls
  always_comb begin
    w_hazard = 1'b0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (issue_src_vld[j] && w_busy[issue_src[j*REG_W +: REG_W]] &&
          !((ZERO_REG != 0) && (issue_src[j*REG_W +: REG_W] == '0))) begin
        w_hazard = 1'b1;
      end
    end
    w_hazard = w_hazard & issue_valid;
  end

  assign w_lat_sat   = (32'(issue_lat) > MAX_LAT) ? LAT_W'(MAX_LAT) : issue_lat;
  assign issue_ready = w_run & issue_valid & ~w_hazard & ~flush & ~hlt_req;
  assign stall       = w_run & w_hazard & ~flush;

  generate
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
      assign w_load[r] = issue_ready & issue_wr & (issue_dst == REG_W'(r)) &
                         !((ZERO_REG != 0) && (r == 0));

      sb_entry #(
        .LAT_W (LAT_W)
      ) u_entry (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load[r]),
        .i_lat       (w_lat_sat),
        .i_clear     (flush),
        .o_busy      (w_busy[r]),
        .o_busy_next (w_busy_next[r])
      );
    end
  endgenerate

  assign busy_mask = w_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Drain completes on the edge that empties the last counter
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:    if (hlt_req) w_state_next = ST_DRAIN;
      ST_DRAIN:  if (w_busy_next == '0) w_state_next = ST_HALTED;
      ST_HALTED: w_state_next = ST_HALTED;
      default:   w_state_next = ST_RUN;
    endcase
  end

  always_comb begin
    w_run  = (r_state == ST_RUN);
    halted = (r_state == ST_HALTED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_count = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_scoreboard
// Brief   : Directed self-checking bench; ZERO_REG=1 and ZERO_REG=0 instances
//           share one stimulus stream.
// Rev     : 1.0
// ============================================================================
module tb_hazard_scoreboard;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [7:0]  issue_src;
  logic [1:0]  issue_src_vld;
  logic        issue_wr;
  logic [3:0]  issue_dst;
  logic [1:0]  issue_lat;
  logic        flush;
  logic        hlt_req;

  logic        rdy1, stl1, hlt1;
  logic [15:0] bm1, sc1;
  logic        rdy0, stl0, hlt0;
  logic [15:0] bm0, sc0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_src(issue_src),
    .issue_src_vld(issue_src_vld), .issue_wr(issue_wr), .issue_dst(issue_dst),
    .issue_lat(issue_lat), .flush(flush), .hlt_req(hlt_req),
    .issue_ready(rdy1), .stall(stl1), .busy_mask(bm1), .halted(hlt1),
    .stall_count(sc1)
  );

  hazard_scoreboard #(.ZERO_REG(0)) dut0 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_src(issue_src),
    .issue_src_vld(issue_src_vld), .issue_wr(issue_wr), .issue_dst(issue_dst),
    .issue_lat(issue_lat), .flush(flush), .hlt_req(hlt_req),
    .issue_ready(rdy0), .stall(stl0), .busy_mask(bm0), .halted(hlt0),
    .stall_count(sc0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_src = '0; issue_src_vld = '0; issue_wr = 1'b0;
    issue_dst = '0; issue_lat = '0; flush = 1'b0; hlt_req = 1'b0;
  endtask

  task automatic drv_wr(input logic [3:0] dst, input logic [1:0] lat);
    idle();
    issue_valid = 1'b1; issue_wr = 1'b1; issue_dst = dst; issue_lat = lat;
  endtask

  task automatic drv_rd(input logic [3:0] s0, input logic [3:0] s1, input logic [1:0] vld);
    idle();
    issue_valid = 1'b1; issue_src = {s1, s0}; issue_src_vld = vld;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", rdy1, 0);
    chk("rst_stall", stl1, 0);
    chk("rst_busy", bm1, 0);
    chk("rst_halted", hlt1, 0);
    chk("rst_scount", sc1, 0);
    rst = 1'b0;

    // Load-use bubble
    drv_wr(4'd3, 2'(LAT_LOAD));
    #1 chk("lu_wr_ready", rdy1, 1);
    tick();
    drv_rd(4'd3, 4'd0, 2'b01);
    #1 chk("lu_stall", stl1, 1);
    chk("lu_not_ready", rdy1, 0);
    chk("lu_busy", bm1, 16'h0008);
    tick();
    chk("lu_stall_gone", stl1, 0);
    chk("lu_ready", rdy1, 1);
    chk("lu_scount", sc1, 1);
    tick();

    // ALU back-to-back
    drv_wr(4'd5, 2'(LAT_ALU));
    tick();
    drv_rd(4'd0, 4'd5, 2'b10);
    #1 chk("alu_stall", stl1, 0);
    chk("alu_ready", rdy1, 1);
    chk("alu_busy", bm1, 0);
    tick();

    // Register zero: hardwired on dut, ordinary on dut0
    drv_wr(4'd0, 2'd3);
    tick();
    drv_rd(4'd0, 4'd0, 2'b01);
    #1 chk("z1_stall", stl1, 0);
    chk("z1_busy0", bm1[0], 0);
    chk("z0_stall_c1", stl0, 1);
    chk("z0_busy0", bm0[0], 1);
    tick();
    chk("z0_stall_c2", stl0, 1);
    tick();
    chk("z0_stall_c3", stl0, 1);
    tick();
    chk("z0_stall_end", stl0, 0);
    chk("z0_ready", rdy0, 1);
    chk("z0_scount", sc0, 4);
    chk("z1_scount", sc1, 1);
    idle();
    tick();

    // Flush priority
    drv_wr(4'd7, 2'd3);
    tick();
    drv_rd(4'd7, 4'd0, 2'b01);
    flush = 1'b1;
    #1 chk("fl_ready", rdy1, 0);
    chk("fl_stall", stl1, 0);
    chk("fl_busy_pre", bm1, 16'h0080);
    tick();
    flush = 1'b0;
    #1 chk("fl_busy_post", bm1, 0);
    chk("fl_ready_post", rdy1, 1);
    chk("fl_stall_post", stl1, 0);
    tick();

    // Youngest writer reload
    drv_wr(4'd4, 2'd3);
    tick();
    drv_wr(4'd4, 2'd1);
    #1 chk("ow_ready", rdy1, 1);
    chk("ow_busy_a", bm1, 16'h0010);
    tick();
    idle();
    #1 chk("ow_busy_b", bm1, 16'h0010);
    tick();
    chk("ow_busy_clear", bm1, 0);

    // Halt drain
    drv_wr(4'd2, 2'd3);
    tick();
    idle();
    hlt_req = 1'b1;
    #1 chk("hd_ready_req", rdy1, 0);
    chk("hd_busy", bm1, 16'h0004);
    chk("hd_halted_c1", hlt1, 0);
    tick();
    drv_rd(4'd2, 4'd0, 2'b01);
    hlt_req = 1'b1;
    #1 chk("hd_drain_ready", rdy1, 0);
    chk("hd_drain_stall", stl1, 0);
    chk("hd_halted_c2", hlt1, 0);
    tick();
    chk("hd_halted_c3", hlt1, 0);
    tick();
    chk("hd_halted", hlt1, 1);
    chk("hd_busy_done", bm1, 0);
    idle();
    drv_rd(4'd5, 4'd0, 2'b01);
    tick();
    chk("hd_sticky", hlt1, 1);
    chk("hd_sticky_ready", rdy1, 0);

    // Reset mid-drain
    do_reset();
    drv_wr(4'd2, 2'd3);
    tick();
    idle();
    hlt_req = 1'b1;
    tick();
    hlt_req = 1'b0;
    rst = 1'b1;
    #1 chk("rd_halted", hlt1, 0);
    chk("rd_busy", bm1, 0);
    chk("rd_scount", sc1, 0);
    rst = 1'b0;
    drv_rd(4'd2, 4'd0, 2'b01);
    #1 chk("rd_ready", rdy1, 1);
    chk("rd_stall", stl1, 0);
    tick();

    // Stall-count saturation: 3 stalls per 4-cycle group
    do_reset();
    for (int g = 0; g < 21846; g++) begin
      drv_wr(4'd4, 2'd3);
      tick();
      drv_rd(4'd4, 4'd0, 2'b01);
      repeat (3) tick();
      if (g == 9) chk("sat_mid", sc1, 30);
      if (g == 21844) chk("sat_full", sc1, 16'hFFFF);
    end
    chk("sat_hold", sc1, 16'hFFFF);
    chk("sat_hold0", sc0, 16'hFFFF);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
